// File: rtl/apb_timer_mc.sv
// ---------------------------------------------------------------------------
// apb_timer_mc -- multi-channel APB timer with PWM outputs and interrupts.
//
// Each channel: prescaler, auto-reload up-counter, compare register, PWM
// output, one-shot mode, update/compare flags. One APB slave (one wait state)
// decodes all channels; channel = PADDR[7:5], register = PADDR[4:2].
//
// Ports:
//   PCLK, PRESET     clock, asynchronous active-high reset
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA   APB request
//   PRDATA/PREADY/PSLVERR              APB response (registered)
//   pwm_o[NUM_CH]    per-channel PWM output (registered)
//   irq              OR of enabled channel flags (registered)
// ---------------------------------------------------------------------------

// Per-channel counter datapath and registers.
//   wr_*     one-cycle write strobes from the APB decode
//   wdata    APB write data
//   en..ccif register state, exposed for readback
//   pwm      registered PWM level, flag = pending enabled interrupt
module apb_timer_ch #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_ctrl,
   input  logic             wr_psc,
   input  logic             wr_arr,
   input  logic             wr_cmp,
   input  logic             wr_stat,
   input  logic [31:0]      wdata,
   output logic             en,
   output logic             oneshot,
   output logic             irq_en,
   output logic             pol,
   output logic [CNT_W-1:0] cnt,
   output logic [CNT_W-1:0] psc,
   output logic [CNT_W-1:0] arr,
   output logic [CNT_W-1:0] cmp,
   output logic             uif,
   output logic             ccif,
   output logic             pwm,
   output logic             flag
);

   logic [CNT_W-1:0] psc_cnt;
   logic             tick, wrap, hit, clr;

   assign tick = en & (psc_cnt == psc);
   // >= so that an ARR lowered below the running count wraps on the next tick
   assign wrap = tick & (cnt >= arr);
   assign hit  = tick & (cnt == cmp);
   assign clr  = wr_ctrl & wdata[1];
   assign flag = (uif | ccif) & irq_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         psc_cnt <= '0;
         cnt     <= '0;
         en      <= 1'b0;
         oneshot <= 1'b0;
         irq_en  <= 1'b0;
         pol     <= 1'b0;
         psc     <= '0;
         arr     <= '0;
         cmp     <= '0;
         uif     <= 1'b0;
         ccif    <= 1'b0;
         pwm     <= 1'b0;
      end else begin
         // CLR overrides any tick on the same edge
         if (clr)
            psc_cnt <= '0;
         else if (en)
            psc_cnt <= tick ? '0 : psc_cnt + CNT_W'(1);

         if (clr)
            cnt <= '0;
         else if (tick)
            cnt <= wrap ? '0 : cnt + CNT_W'(1);

         // software write to CTRL beats the one-shot hardware clear
         if (wr_ctrl) begin
            en      <= wdata[0];
            oneshot <= wdata[2];
            irq_en  <= wdata[3];
            pol     <= wdata[4];
         end else if (wrap & oneshot) begin
            en <= 1'b0;
         end

         if (wr_psc) psc <= wdata[CNT_W-1:0];
         if (wr_arr) arr <= wdata[CNT_W-1:0];
         if (wr_cmp) cmp <= wdata[CNT_W-1:0];

         // hardware set wins over a W1C on the same edge
         uif  <= wrap | (uif  & ~(wr_stat & wdata[0]));
         ccif <= hit  | (ccif & ~(wr_stat & wdata[1]));

         pwm <= en ? ((cnt < cmp) ^ pol) : pol;
      end
   end

endmodule

module apb_timer_mc #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 32
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic [7:0]        PADDR,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [31:0]       PWDATA,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic [NUM_CH-1:0] pwm_o,
   output logic              irq
);

   logic [2:0] ch_sel, reg_sel;
   logic       access, wr, ch_ok;
   logic       unused_addr;
   logic [31:0] rdata;

   logic [NUM_CH-1:0][CNT_W-1:0] cnt, psc, arr, cmp;
   logic [NUM_CH-1:0]            en, oneshot, irq_en, pol, uif, ccif, flag;

   assign ch_sel      = PADDR[7:5];
   assign reg_sel     = PADDR[4:2];
   assign unused_addr = ^PADDR[1:0];
   assign ch_ok       = int'(ch_sel) < NUM_CH;
   // setup/access phase seen while not yet ready -> respond next cycle
   assign access      = PSEL & PENABLE & ~PREADY;
   assign wr          = PSEL & PENABLE & PREADY & PWRITE;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic sel;
      assign sel = wr & (ch_sel == 3'(i));

      apb_timer_ch #(.CNT_W(CNT_W)) u_ch (
         .clk     (PCLK),
         .rst     (PRESET),
         .wr_ctrl (sel & (reg_sel == 3'd0)),
         .wr_psc  (sel & (reg_sel == 3'd2)),
         .wr_arr  (sel & (reg_sel == 3'd3)),
         .wr_cmp  (sel & (reg_sel == 3'd4)),
         .wr_stat (sel & (reg_sel == 3'd5)),
         .wdata   (PWDATA),
         .en      (en[i]),
         .oneshot (oneshot[i]),
         .irq_en  (irq_en[i]),
         .pol     (pol[i]),
         .cnt     (cnt[i]),
         .psc     (psc[i]),
         .arr     (arr[i]),
         .cmp     (cmp[i]),
         .uif     (uif[i]),
         .ccif    (ccif[i]),
         .pwm     (pwm_o[i]),
         .flag    (flag[i])
      );
   end

   // read mux; out-of-range channels and unmapped offsets return 0
   always_comb begin
      rdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_sel == 3'(i)) begin
            case (reg_sel)
               3'd0: rdata[4:0]       = {pol[i], irq_en[i], oneshot[i], 1'b0, en[i]};
               3'd1: rdata[CNT_W-1:0] = cnt[i];
               3'd2: rdata[CNT_W-1:0] = psc[i];
               3'd3: rdata[CNT_W-1:0] = arr[i];
               3'd4: rdata[CNT_W-1:0] = cmp[i];
               3'd5: rdata[1:0]       = {ccif[i], uif[i]};
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         PREADY  <= 1'b0;
         PRDATA  <= '0;
         PSLVERR <= 1'b0;
         irq     <= 1'b0;
      end else begin
         PREADY  <= access;
         PSLVERR <= access & ~ch_ok;
         PRDATA  <= (access & ~PWRITE) ? rdata : '0;
         irq     <= |flag;
      end
   end

endmodule

// File: tb/tb_apb_timer_mc.sv
// ---------------------------------------------------------------------------
// tb_apb_timer_mc -- self-checking bench for apb_timer_mc.
// A behavioural channel model tracks every register and predicts the APB
// response, pwm_o and irq each cycle; directed scenarios add literal checks.
// ---------------------------------------------------------------------------
module tb_apb_timer_mc;

   localparam int NUM_CH = 2;
   localparam int CNT_W  = 32;

   logic              PCLK, PRESET;
   logic [7:0]        PADDR;
   logic              PSEL, PENABLE, PWRITE;
   logic [31:0]       PWDATA;
   logic [31:0]       PRDATA;
   logic              PREADY, PSLVERR;
   logic [NUM_CH-1:0] pwm_o;
   logic              irq;

   int checks = 0;
   int errors = 0;

   apb_timer_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .PADDR   (PADDR),
      .PSEL    (PSEL),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PWDATA  (PWDATA),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .PSLVERR (PSLVERR),
      .pwm_o   (pwm_o),
      .irq     (irq)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // ---------------- behavioural model ----------------
   logic [31:0] m_cnt [NUM_CH], m_pcnt [NUM_CH], m_psc [NUM_CH], m_arr [NUM_CH], m_cmp [NUM_CH];
   logic        m_en [NUM_CH], m_one [NUM_CH], m_irqen [NUM_CH], m_pol [NUM_CH];
   logic        m_uif [NUM_CH], m_ccif [NUM_CH];
   logic [NUM_CH-1:0] m_pwm;
   logic        m_ready, m_slverr, m_irq;
   logic [31:0] m_rdata;

   logic        acc, wr, tick, wrap, hit, sw, any;
   int          c, r;
   logic [31:0] wd, rd;

   function automatic logic [31:0] mread(int ch, int rg);
      case (rg)
         0: return {27'd0, m_pol[ch], m_irqen[ch], m_one[ch], 1'b0, m_en[ch]};
         1: return m_cnt[ch];
         2: return m_psc[ch];
         3: return m_arr[ch];
         4: return m_cmp[ch];
         5: return {30'd0, m_ccif[ch], m_uif[ch]};
         default: return 32'd0;
      endcase
   endfunction

   initial begin
      forever begin
         @(posedge PCLK or posedge PRESET);
         if (PRESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
               m_cnt[i] = 0; m_pcnt[i] = 0; m_psc[i] = 0; m_arr[i] = 0; m_cmp[i] = 0;
               m_en[i] = 0; m_one[i] = 0; m_irqen[i] = 0; m_pol[i] = 0;
               m_uif[i] = 0; m_ccif[i] = 0;
            end
            m_pwm = '0; m_ready = 0; m_slverr = 0; m_irq = 0; m_rdata = 0;
         end else begin
            acc = PSEL && PENABLE && !m_ready;
            wr  = PSEL && PENABLE && m_ready && PWRITE;
            c   = int'(PADDR[7:5]);
            r   = int'(PADDR[4:2]);
            wd  = PWDATA;
            rd  = (acc && !PWRITE && c < NUM_CH) ? mread(c, r) : 32'd0;
            any = 0;
            for (int i = 0; i < NUM_CH; i++)
               any = any | ((m_uif[i] | m_ccif[i]) & m_irqen[i]);
            for (int i = 0; i < NUM_CH; i++) begin
               tick = m_en[i] && (m_pcnt[i] == m_psc[i]);
               wrap = tick && (m_cnt[i] >= m_arr[i]);
               hit  = tick && (m_cnt[i] == m_cmp[i]);
               m_pwm[i] = m_en[i] ? ((m_cnt[i] < m_cmp[i]) ^ m_pol[i]) : m_pol[i];
               if (m_en[i]) m_pcnt[i] = tick ? 0 : m_pcnt[i] + 1;
               if (tick)    m_cnt[i]  = wrap ? 0 : m_cnt[i] + 1;
               if (wrap && m_one[i]) m_en[i] = 0;
               sw = wr && (c == i);
               if (sw && r == 5) begin
                  if (wd[0]) m_uif[i]  = 0;
                  if (wd[1]) m_ccif[i] = 0;
               end
               if (wrap) m_uif[i]  = 1;
               if (hit)  m_ccif[i] = 1;
               if (sw && r == 0) begin
                  m_en[i] = wd[0]; m_one[i] = wd[2]; m_irqen[i] = wd[3]; m_pol[i] = wd[4];
                  if (wd[1]) begin m_pcnt[i] = 0; m_cnt[i] = 0; end
               end
               if (sw && r == 2) m_psc[i] = wd;
               if (sw && r == 3) m_arr[i] = wd;
               if (sw && r == 4) m_cmp[i] = wd;
            end
            m_irq    = any;
            m_ready  = acc;
            m_slverr = acc && (c >= NUM_CH);
            m_rdata  = rd;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge PCLK);
         chk("cyc_pready",  32'(PREADY),  32'(m_ready));
         chk("cyc_prdata",  PRDATA,       m_rdata);
         chk("cyc_pslverr", 32'(PSLVERR), 32'(m_slverr));
         chk("cyc_pwm",     32'(pwm_o),   32'(m_pwm));
         chk("cyc_irq",     32'(irq),     32'(m_irq));
      end
   end

   // ---------------- APB tasks ----------------
   task automatic apb_xfer(input logic wrt, input logic [7:0] a, input logic [31:0] wdat,
                           output logic [31:0] d, output logic e);
      bit done = 0;
      d = 0; e = 0;
      @(posedge PCLK); #1;
      PSEL = 1; PENABLE = 0; PWRITE = wrt; PADDR = a; PWDATA = wdat;
      @(posedge PCLK); #1;
      PENABLE = 1;
      for (int k = 0; k < 8 && !done; k++) begin
         @(negedge PCLK);
         if (PREADY) begin d = PRDATA; e = PSLVERR; done = 1; end
         @(posedge PCLK);
      end
      #1;
      PSEL = 0; PENABLE = 0; PWRITE = 0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL apb_timeout: addr 0x%02h got no PREADY expected PREADY=1", a);
      end
   endtask

   task automatic apb_write(input logic [7:0] a, input logic [31:0] wdat);
      logic [31:0] d; logic e;
      apb_xfer(1'b1, a, wdat, d, e);
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
      apb_xfer(1'b0, a, 32'd0, d, e);
   endtask

   // ---------------- directed scenarios ----------------
   logic [31:0] rdv, expv;
   logic        rerr;
   int          cntv;
   bit          found;
   int          seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

   initial begin
      PRESET = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      chk("rst_prdata",  PRDATA,        32'd0);
      chk("rst_pready",  32'(PREADY),   32'd0);
      chk("rst_pslverr", 32'(PSLVERR),  32'd0);
      chk("rst_pwm",     32'(pwm_o),    32'd0);
      chk("rst_irq",     32'(irq),      32'd0);
      @(posedge PCLK); #1 PRESET = 0;

      // reset in the middle of a write to ch0 PSC
      apb_write(8'h08, 32'd7);
      @(posedge PCLK); #1;
      PSEL = 1; PWRITE = 1; PADDR = 8'h08; PWDATA = 32'd5;
      @(posedge PCLK); #1 PENABLE = 1;
      @(posedge PCLK); #1 PRESET = 1;
      #2;
      chk("midrst_pready", 32'(PREADY), 32'd0);
      chk("midrst_prdata", PRDATA,      32'd0);
      PSEL = 0; PENABLE = 0; PWRITE = 0;
      @(posedge PCLK); #1 PRESET = 0;
      apb_read(8'h08, rdv, rerr);
      chk("midrst_psc", rdv, 32'd0);

      // period: PSC=1, ARR=3
      apb_write(8'h08, 32'd1);
      apb_write(8'h0C, 32'd3);
      apb_write(8'h00, 32'h1);
      for (int k = 0; k < 9; k++) begin
         if (k > 0) @(posedge PCLK);
         @(negedge PCLK);
         chk($sformatf("period_cnt%0d", k), m_cnt[0], 32'(seq[k]));
         if (k == 7) chk("period_uif_before", 32'(m_uif[0]), 32'd0);
         if (k == 8) chk("period_uif_after",  32'(m_uif[0]), 32'd1);
      end
      apb_read(8'h14, rdv, rerr);
      chk("period_status_uif", rdv & 32'h1, 32'h1);

      // one-shot on ch1: PSC=0, ARR=4
      apb_write(8'h2C, 32'd4);
      apb_write(8'h20, 32'h5);
      repeat (10) @(posedge PCLK);
      apb_read(8'h20, rdv, rerr);
      chk("oneshot_ctrl", rdv, 32'h4);
      apb_read(8'h34, rdv, rerr);
      chk("oneshot_status", rdv, 32'h3);
      apb_read(8'h24, rdv, rerr);
      chk("oneshot_cnt", rdv, 32'd0);

      // PWM + irq on ch0: PSC=0, ARR=9, CMP=3, IRQ_EN
      apb_write(8'h00, 32'h0);
      apb_write(8'h14, 32'h3);
      apb_write(8'h08, 32'd0);
      apb_write(8'h0C, 32'd9);
      apb_write(8'h10, 32'd3);
      apb_write(8'h00, 32'hB);
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge PCLK);
         if (irq) found = 1;
      end
      chk("irq_rise", 32'(found), 32'd1);
      repeat (5) @(posedge PCLK);
      cntv = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge PCLK);
         cntv += int'(pwm_o[0]);
      end
      chk("pwm_duty_20cyc", 32'(cntv), 32'd6);
      apb_write(8'h00, 32'h8);
      apb_write(8'h14, 32'h3);
      @(negedge PCLK);
      chk("irq_w1c_edge", 32'(irq), 32'd1);
      @(negedge PCLK);
      chk("irq_w1c_drop", 32'(irq), 32'd0);

      // W1C of CCIF on the very edge the compare hits (cnt 3 at commit)
      apb_write(8'h00, 32'hB);
      found = 0;
      for (int k = 0; k < 30 && !found; k++) begin
         @(negedge PCLK);
         if (m_cnt[0] == 0) found = 1;
      end
      chk("race_sync", 32'(found), 32'd1);
      apb_write(8'h14, 32'h2);
      apb_read(8'h14, rdv, rerr);
      chk("set_beats_w1c", (rdv >> 1) & 32'h1, 32'h1);

      // addressing
      apb_write(8'h00, 32'h8);
      apb_read(8'h48, rdv, rerr);
      chk("badch_rdata",  rdv,         32'd0);
      chk("badch_slverr", 32'(rerr),   32'd1);
      apb_read(8'h18, rdv, rerr);
      chk("off18_rdata",  rdv,         32'd0);
      chk("off18_slverr", 32'(rerr),   32'd0);
      expv = m_cnt[0];
      apb_write(8'h04, 32'h55);
      apb_read(8'h04, rdv, rerr);
      chk("cnt_ro", rdv, expv);

      // CLR race on ch1: PSC=0, ARR=100, CMP=200
      apb_write(8'h2C, 32'd100);
      apb_write(8'h30, 32'd200);
      apb_write(8'h20, 32'h3);
      repeat (5) @(posedge PCLK);
      apb_write(8'h20, 32'h3);
      apb_read(8'h24, rdv, rerr);
      chk("clr_race_cnt", rdv, 32'd2);

      repeat (3) @(posedge PCLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/apb_timer_mc.md
Name: apb_timer_mc

Overview:
Multi-channel APB timer peripheral, the parametrised successor to the single-channel APB timer. Each channel has a prescaler, an auto-reload up-counter, a compare register, a PWM output, one-shot mode and interrupt flags. One APB slave decodes all channels. Sits on the APB bus beside the other peripherals; pwm_o drives pins, irq goes to the interrupt controller.

Parameters:
NUM_CH, 2, number of timer channels (1..8)
CNT_W, 32, width of the prescaler, counter, ARR and CMP (8..32); registers are zero-extended to 32 bits on read

Ports:
PCLK  in  1  clock
PRESET  in  1  asynchronous active-high reset
PADDR  in  8  byte address; [7:5] channel, [4:2] register, [1:0] ignored
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  1=write
PWDATA  in  32  write data
PRDATA  out  32  read data, valid while PREADY=1
PREADY  out  1  transfer complete
PSLVERR  out  1  error response, valid while PREADY=1
pwm_o  out  NUM_CH  per-channel PWM output
irq  out  1  OR of the enabled per-channel flags

Behaviour:
Clock and reset:
- One clock, PCLK. PRESET is asynchronous active-high.
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, pwm_o=0, irq=0. All registers, counters and flags are 0.

APB timing (one wait state):
- PREADY is registered. It is 1 for exactly one cycle, the cycle after PSEL&PENABLE is first seen. It returns to 0 the following cycle.
- A write commits on the edge where PSEL&PENABLE&PREADY=1.
- PRDATA and PSLVERR are registered alongside PREADY.
- PRDATA=0 whenever PREADY=0, and for writes.

Register map (per channel, base = ch*0x20):
- 0x00 CTRL: [0] EN, [1] CLR, [2] ONESHOT, [3] IRQ_EN, [4] POL.
  - CLR is self-clearing and always reads 0.
- 0x04 CNT: read-only. Writes are ignored.
- 0x08 PSC, 0x0C ARR, 0x10 CMP: read/write.
- 0x14 STATUS: [0] UIF (update), [1] CCIF (compare). Write 1 to clear.
- Offsets 0x18 and 0x1C read 0; writes are ignored.
- Channel index >= NUM_CH: reads 0, writes ignored, PSLVERR=1.

Counter datapath (per channel):
- tick = EN & (psc_cnt==PSC).
- When EN=1: psc_cnt increments, and wraps to 0 when tick.
- When EN=0: psc_cnt and cnt hold.
- On tick:
  - if cnt>=ARR: cnt<=0, set UIF, and if ONESHOT clear EN (hardware write);
  - otherwise cnt<=cnt+1.
- Using >= lets a reduced ARR below the current cnt wrap on the next tick.
- On tick with cnt==CMP: set CCIF.
- Update rate = f_PCLK / ((PSC+1)*(ARR+1)). PSC=0 gives a tick every cycle.

CLR:
- A CLR write zeroes psc_cnt and cnt the same edge. Flags are not affected.
- The EN bit written in the same write takes effect.
- CLR wins over a simultaneous tick.

Flags:
- A hardware set and a software W1C on the same edge: the set wins.
- A software write to CTRL.EN on the same edge as a one-shot hardware clear: the software value wins.

PWM:
- pwm_o[ch] is registered: pwm_o <= EN ? ((cnt<CMP)^POL) : POL. Latency is one cycle from cnt.
- CMP=0 gives a constant POL level.
- CMP>ARR gives a constant ~POL level while running.

Interrupt:
- irq is registered: irq <= OR over ch of ((UIF|CCIF) & IRQ_EN).
- It drops one cycle after the last enabled flag clears.

Reset mid-operation:
- PRESET asserted at any time, including during an APB transfer, returns all state to reset values immediately.
- An interrupted transfer is not completed.

Test Plan:
- Reset: assert PRESET during a pending write to ch0 PSC -> PREADY=0, PRDATA=0, and PSC reads 0 after release.
- Period: ch0 PSC=1, ARR=3, CTRL=0x1 -> cnt sequence 0,0,1,1,2,2,3,3,0. UIF set at 8 cycles after EN. CNT read matches.
- One-shot: ch1 PSC=0, ARR=4, CTRL=0x5 -> counts 0..4, wraps to 0. EN reads 0 and UIF=1, then cnt holds at 0.
- PWM and irq: ch0 PSC=0, ARR=9, CMP=3, POL=0, IRQ_EN=1 -> pwm_o[0] high 3 of every 10 cycles. irq rises after the CCIF set. W1C of 0x3 drops irq one cycle later. A set coinciding with W1C keeps the flag 1.
- Addressing: read 0x48 (ch2) with NUM_CH=2 -> PRDATA=0, PSLVERR=1. A write to 0x04 leaves CNT unchanged.
- CLR race: write CTRL=0x3 on the cycle cnt would increment -> cnt=0, counting resumes from 0.
